fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter N, default 32, meaning datapath/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 2, meaning prefetch buffer entries (power of two, >=2).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  synchronous active-low reset.
REQ-007 SHALL have port imem_req  output  1  instruction memory read request.
REQ-008 SHALL have port imem_addr  output  N  word-aligned fetch address.
REQ-009 SHALL have port imem_ack  input  1  one-cycle pulse, imem_rdata valid.
REQ-010 SHALL have port imem_rdata  input  N  fetched instruction word.
REQ-011 SHALL have port instruction  output  N  instruction presented to datapath.
REQ-012 SHALL have port pc  output  N  address of presented instruction.
REQ-013 SHALL have port instr_valid  output  1  instruction/pc valid.
REQ-014 SHALL have port instr_ready  input  1  datapath accepts presented instruction.
REQ-015 SHALL have port redirect  input  1  branch/jump taken, flush and refetch.
REQ-016 SHALL have port redirect_pc  input  N  new fetch address.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, DROP; imem_req is registered and high exactly in WAIT and DROP.
REQ-018 SHALL hold imem_addr = fetch_pc, stable throughout WAIT/DROP.
REQ-019 SHALL leave IDLE for WAIT when (count + 0) < DEPTH and redirect=0; at most one request outstanding.
REQ-020 SHALL sample imem_ack only in WAIT/DROP; ack in IDLE ignored.
REQ-021 WAIT + ack: push {fetch_pc, imem_rdata} into buffer, fetch_pc <= fetch_pc + 4 (mod 2^N), go IDLE.
REQ-022 DROP + ack: discard data, go IDLE; fetch_pc unchanged.
REQ-023 Buffer is FIFO; instr_valid = (count != 0); instruction/pc = head entry; both 0 when empty.
REQ-024 Transfer occurs when instr_valid & instr_ready; head popped at that edge.
REQ-025 Simultaneous push and pop: count unchanged, order preserved; pop on empty ignored; push never occurs when full (guaranteed by REQ-019).
REQ-026 Minimum fetch latency: request issued cycle t, ack at t+k (k>=1), instr_valid high at t+k+1.
REQ-027 redirect has priority over every other event: buffer flushed (count=0, instr_valid=0 next cycle), fetch_pc <= {redirect_pc[N-1:2], 2'b00}.
REQ-028 redirect in WAIT without ack: go DROP; in WAIT with ack same cycle: data discarded, go IDLE; in DROP: stay DROP until ack; in IDLE: stay IDLE.
REQ-029 A transfer in the redirect cycle counts as consumed; no other entry survives.
REQ-030 Back-to-back redirects: last one wins; only one stale ack discarded.
REQ-031 fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no error.

Reset
REQ-032 On reset=0 at a clock edge: state IDLE, fetch_pc = RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, pc=0.
REQ-033 Reset mid-request abandons it; acks arriving during or after reset, before a new request, are ignored.
REQ-034 First request asserts on the first edge after reset returns to 1.

Verification
REQ-035 Reset release, memory ack 1 cycle after req, ready=1 -> pc sequence 0x0, 0x4, 0x8 with matching rdata, one instruction per 2 cycles.
REQ-036 ready=0, 4 acks offered -> exactly DEPTH=2 entries buffered, imem_req stays 0 when full; ready=1 -> 0x0, 0x4 delivered in order, fetching resumes at 0x8.
REQ-037 redirect with redirect_pc=0x0000_0103 while in WAIT -> instr_valid=0 next cycle, stale ack discarded, next delivered pc=0x0000_0100.
REQ-038 redirect coincident with ack -> ack data not delivered, next request addr = redirect target.
REQ-039 reset=0 while WAIT, ack one cycle later -> no instruction delivered, first post-reset imem_addr=RESET_PC.
REQ-040 RESET_PC=32'hFFFF_FFFC -> delivered pcs 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding a small prefetch FIFO, with redirect flush.
// One memory request outstanding at a time; a redirect mid-request drops the stale response.
module fetch_unit #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = 32'h0000_0000,
    parameter int             DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instruction,
    output logic [N-1:0] pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state, state_n;
    logic [N-1:0]  fetch_pc;
    logic [N-1:0]  fifo_pc  [DEPTH];
    logic [N-1:0]  fifo_ins [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          push, pop;

    assign push        = state == WAIT && imem_ack && !redirect;
    assign pop         = instr_valid && instr_ready;
    assign instr_valid = count != '0;
    assign instruction = instr_valid ? fifo_ins[head] : '0;
    assign pc          = instr_valid ? fifo_pc[head] : '0;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = (!redirect && count < CW'(DEPTH)) ? WAIT : IDLE;
            WAIT:    state_n = imem_ack ? IDLE : (redirect ? DROP : WAIT);
            DROP:    state_n = imem_ack ? IDLE : DROP;
            default: state_n = IDLE;
        endcase
    end

    // imem_addr is latched at issue so a redirect during the request cannot disturb it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            state    <= state_n;
            imem_req <= state_n != IDLE;
            if (state == IDLE && state_n == WAIT)
                imem_addr <= fetch_pc;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~N'(3);
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + N'(4);
                    tail     <= tail + AW'(1);
                end
                if (pop)
                    head <= head + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[tail]  <= fetch_pc;
            fifo_ins[tail] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus; a queue of expected fetch addresses is
// consumed by a negedge monitor. A second instance checks address wrap from 0xFFFF_FFFC.
module tb_fetch_unit;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

    logic        clk;
    logic        reset, ready, redirect;
    logic [31:0] redirect_pc;
    logic        req0, ack0, vld0;
    logic [31:0] addr0, rdata0, ins0, pc0;
    logic        req1, ack1, vld1;
    logic [31:0] addr1, rdata1, ins1, pc1;

    int errors = 0, checks = 0;
    int lat_mode = 0;

    fetch_unit #(.N(32), .RESET_PC(32'h0), .DEPTH(2)) dut0 (
        .clk(clk), .reset(reset), .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0),
        .imem_rdata(rdata0), .instruction(ins0), .pc(pc0), .instr_valid(vld0),
        .instr_ready(ready), .redirect(redirect), .redirect_pc(redirect_pc));

    fetch_unit #(.N(32), .RESET_PC(RPC1), .DEPTH(2)) dut1 (
        .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1),
        .imem_rdata(rdata1), .instruction(ins1), .pc(pc1), .instr_valid(vld1),
        .instr_ready(1'b1), .redirect(1'b0), .redirect_pc(32'h0));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_new_req();
        int n = 0;
        while (req0 && n < 50) begin tick(); n++; end
        while (!req0 && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            errors++;
            checks++;
            $display("FAIL wait_req: timeout got req=%b expected 1", req0);
        end
    endtask

    // memory for dut0: latency 0..2 cycles after the request is first seen
    initial begin
        bit busy = 0;
        int wait_c = 0;
        ack0 = 0;
        rdata0 = 0;
        forever begin
            @(posedge clk);
            #1;
            ack0 = 0;
            if (busy) begin
                if (wait_c == 0) begin ack0 = 1; busy = 0; end
                else wait_c--;
            end else if (req0) begin
                wait_c = lat_mode < 0 ? int'($urandom_range(0, 2)) : lat_mode;
                if (wait_c == 0) ack0 = 1;
                else begin busy = 1; wait_c--; end
            end
            rdata0 = ack0 ? mem(addr0) : $urandom;
        end
    end

    initial begin
        ack1 = 0;
        rdata1 = 0;
        forever begin
            @(posedge clk);
            #1;
            ack1 = req1 && !ack1;
            rdata1 = ack1 ? mem(addr1) : $urandom;
        end
    end

    logic [31:0] exp_q[$];
    int          cyc = 0, xfers = 0;
    int          xfer_cyc[$];
    bit          chk_rst = 0, chk_flush = 0, prev_req = 0, wrapped = 0;
    logic [31:0] prev_addr = 0, exp1 = RPC1;

    always @(negedge clk) begin
        logic [31:0] e;
        cyc++;
        if (chk_rst) begin
            chk("rst_req", 32'(req0), 0);
            chk("rst_addr", addr0, 0);
            chk("rst_valid", 32'(vld0), 0);
            chk("rst_instr", ins0, 0);
            chk("rst_pc", pc0, 0);
        end else if (chk_flush) chk("flush_valid", 32'(vld0), 0);
        chk_rst = 0;
        chk_flush = 0;
        if (!reset) begin
            exp_q.delete();
            exp_q.push_back(32'h0);
            chk_rst = 1;
        end else begin
            if (req0 && prev_req) chk("addr_stable", addr0, prev_addr);
            if (req0) chk("addr_align", 32'(addr0[1:0]), 0);
            if (!vld0) begin
                chk("empty_pc", pc0, 0);
                chk("empty_instr", ins0, 0);
            end
            if (vld0 && ready) begin
                if (exp_q.size() == 0) exp_q.push_back(32'h0);
                e = exp_q.pop_front();
                chk("xfer_pc", pc0, e);
                chk("xfer_instr", ins0, mem(e));
                if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
                xfers++;
                xfer_cyc.push_back(cyc);
            end
            if (redirect) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc & ~32'd3);
                chk_flush = 1;
            end
        end
        if (!reset) exp1 = RPC1;
        else if (vld1) begin
            chk("wrap_pc", pc1, exp1);
            chk("wrap_instr", ins1, mem(exp1));
            if (exp1 == 32'h0) wrapped = 1;
            exp1 += 32'd4;
        end
        prev_req = req0;
        prev_addr = addr0;
    end

    initial begin
        int acks;
        reset = 0; ready = 1; redirect = 0; redirect_pc = 0; lat_mode = 0;
        repeat (3) tick();
        // release: request on the first edge, then one instruction every two cycles
        reset = 1;
        tick();
        chk("first_req", 32'(req0), 1);
        chk("first_addr", addr0, 0);
        xfer_cyc.delete();
        repeat (12) tick();
        chk("tput_count", 32'(xfer_cyc.size() >= 4), 1);
        for (int i = 1; i < 4 && i < xfer_cyc.size(); i++)
            chk("tput_gap", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 2);
        // stalled consumer: buffer fills to DEPTH then requests stop
        ready = 0; reset = 0;
        repeat (2) tick();
        lat_mode = -1; reset = 1; acks = 0;
        repeat (20) begin
            tick();
            if (ack0 && req0) acks++;
        end
        chk("fill_acks", 32'(acks), 2);
        chk("full_req", 32'(req0), 0);
        chk("full_valid", 32'(vld0), 1);
        ready = 1;
        wait_new_req();
        chk("resume_addr", addr0, 32'h8);
        repeat (8) tick();
        // redirect while waiting: stale ack dropped
        lat_mode = 2;
        wait_new_req();
        chk("wait_noack", 32'(ack0), 0);
        redirect = 1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 0;
        wait_new_req();
        chk("redir_addr", addr0, 32'h0000_0100);
        repeat (6) tick();
        // redirect coincident with ack
        lat_mode = 0;
        wait_new_req();
        chk("ack_now", 32'(ack0), 1);
        redirect = 1; redirect_pc = 32'h0000_246A;
        tick();
        redirect = 0;
        wait_new_req();
        chk("redir_ack_addr", addr0, 32'h0000_2468);
        repeat (6) tick();
        // reset mid-request, ack arrives one cycle later
        lat_mode = 1;
        wait_new_req();
        reset = 0;
        tick();
        reset = 1;
        wait_new_req();
        chk("post_rst_addr", addr0, 32'h0);
        lat_mode = -1;
        repeat (6) tick();
        repeat (3000) begin
            reset = $urandom_range(0, 99) != 0;
            ready = $urandom_range(0, 3) != 0;
            redirect = $urandom_range(0, 15) == 0;
            redirect_pc = $urandom;
            tick();
        end
        reset = 1; redirect = 0; ready = 1;
        repeat (20) tick();
        chk("progress", 32'(xfers > 500), 1);
        chk("wrap_seen", 32'(wrapped), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
